jk_target_driver: RTL
=====================

# jk_target_driver

Controller that drives the J/K excitation inputs of an external bank of WIDTH JK flip-flops so the bank reaches a requested target value. It accepts a target over a valid/ready handshake and computes per-bit excitation from the bank's fed-back `q`. It then confirms arrival and reports `done`, or reports `err` after a bounded number of retries. It sits upstream of the JK register bank as the producer of its `j`/`k` lines.

## Interface
- `WIDTH`, 4: number of JK flip-flops driven; valid range 1..32.
- `MAX_TRIES`, 3: DRIVE attempts before error; valid range 1..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `clear_n`, input, 1: asynchronous, active-low reset.
- `tgt_valid`, input, 1: target request.
- `tgt_ready`, output, 1: high exactly when state is IDLE.
- `tgt_data`, input, WIDTH: requested bank value.
- `q_fb`, input, WIDTH: `q` outputs of the driven JK bank.
- `j`, output, WIDTH: registered J excitation.
- `k`, output, WIDTH: registered K excitation.
- `busy`, output, 1: high while not IDLE.
- `done`, output, 1: one-cycle pulse; bank matched target.
- `err`, output, 1: one-cycle pulse; retries exhausted without match.

## Operation
- States:
  - IDLE: `j`=`k`=0, so the bank holds.
  - DRIVE: `j`/`k` asserted for exactly one cycle.
  - CHECK: `j`=`k`=0; compare `q_fb` against the latched target.
- IDLE→DRIVE on `tgt_valid & tgt_ready`:
  - Latch `tgt_data` into the target register.
  - Load the tries counter with 1.
  - Register `j`/`k` from the excitation of `q_fb` versus `tgt_data`.
- Excitation per bit, default set/reset form (q,t → j,k):
  - 0,0 → 0,0
  - 0,1 → 1,0
  - 1,0 → 0,1
  - 1,1 → 0,0
  - Never j=k=1 in this form.
- DRIVE→CHECK unconditionally; `j`/`k` return to 0.
- CHECK, `q_fb` == target: `done`=1 for one cycle, go to IDLE.
- CHECK, mismatch, tries < MAX_TRIES:
  - Increment tries.
  - Recompute `j`/`k` from current `q_fb` and go to DRIVE.
- CHECK, mismatch, tries == MAX_TRIES: `err`=1 for one cycle, go to IDLE.
- Target equal to current `q_fb` still runs one DRIVE (all-zero excitation) plus CHECK, then `done`.
- `tgt_valid` while busy is not accepted, since `tgt_ready`=0. The target register is unaffected.
- `tgt_data` is sampled only at acceptance. Later changes are ignored.
- `done` and `err` are never high in the same cycle.

## Timing
- Reset values while `clear_n` is low:
  - `j`=0, `k`=0, `done`=0, `err`=0, `busy`=0.
  - `tgt_ready`=1, state IDLE, tries=0, target register=0.
- Reset is asynchronous and takes effect mid-operation. Any DRIVE in progress is abandoned with no `done`/`err`.
- Acceptance at edge E0:
  - `j`/`k` valid in cycle E0→E1.
  - The bank samples at E1.
  - CHECK compares `q_fb` at E2.
  - `done` is high in cycle E2→E3.
- Minimum latency, accept to `done`: 2 cycles. `tgt_ready` returns in the same cycle as `done`/`err`.
- Each retry adds 2 cycles. Worst-case accept to `err`: 2×MAX_TRIES cycles.
- Back-to-back requests: a new accept is possible at the edge that ends the `done` cycle, giving 3-cycle throughput.
- `q_fb` is sampled only at acceptance and in CHECK. Changes while in DRIVE are ignored.

## Configuration
- `JK_TOGGLE_EN` defined: bits needing change use toggle excitation, j=k=1. Matching bits stay 0,0. All timing and retry behaviour is unchanged.
- `JK_TOGGLE_EN` undefined: set/reset excitation per the table above.

## Structure
- Package `jk_pkg`:
  - State enum typedef: IDLE, DRIVE, CHECK.
  - Tries counter width constant, 4 bits.
  - Excitation function, parameterised by mode.
- Sub-module `jk_excite`: purely combinational. Takes `q`, `t` and WIDTH, outputs `j_next`/`k_next`. The `JK_TOGGLE_EN` selection lives here.
- Top module holds the FSM, target register, tries counter and output registers.

## Test plan
- Reset mid-operation: `clear_n` pulsed low during DRIVE → `j`=`k`=0, `tgt_ready`=1, `busy`/`done`/`err`=0 immediately; no later pulse.
- Set case: `q_fb`=4'b0000, target 4'b1010, behavioural JK bank attached → `j`=1010, `k`=0000 for one cycle; `done` 2 cycles after accept; bank=1010.
- Reset case: `q_fb`=4'b1111, target 4'b0101 → `j`=0000, `k`=1010; `done` at +2.
- Already-at-target: `q_fb`=0110, target 0110 → `j`=`k`=0; `done` at +2.
- Stuck bit: bench forces `q_fb[0]`=0, target 0001, MAX_TRIES=3 → three DRIVE cycles, `err` at +6, no `done`. Also hold `tgt_valid` high while busy → second target accepted only when `tgt_ready` returns.
- Toggle mode, `JK_TOGGLE_EN` defined: `q_fb`=0011, target 0101 → `j`=`k`=0110; `done` at +2.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK target driver.
// Contents: FSM state enum, tries-counter width, per-bit JK excitation function.
// The excitation function takes the mode as an argument so both set/reset and
// toggle forms live in one place; the JK_TOGGLE_EN selection is made by jk_excite.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int TRIES_W = 4;

  // Returns {j, k} for one flip-flop currently at q that must become t.
  // Set/reset form never produces j=k=1; toggle form uses j=k=1 for any change.
  function automatic logic [1:0] jk_bit(input logic toggle_mode, input logic q, input logic t);
    logic [1:0] r;
    if (toggle_mode) begin
      r = {q ^ t, q ^ t};
    end else begin
      r = {~q & t, q & ~t};
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_target_driver_if.sv
// Bundle of target handshake, bank feedback and excitation lines.
// slave  : the driver (accepts targets, reads q_fb, produces j/k and status).
// master : the requester / bank side (issues targets, supplies q_fb).
interface jk_target_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, busy, done, err
  );

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, busy, done, err
  );
endinterface

// File: rtl/jk_excite.sv
// Combinational per-bit JK excitation from current value q to target t.
// Ports: q, t in; j_next, k_next out (all WIDTH bits).
// Macro JK_TOGGLE_EN selects toggle form (j=k=1 on change); default is set/reset form.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j_next,
  output logic [WIDTH-1:0] k_next
);

`ifdef JK_TOGGLE_EN
  localparam logic TOGGLE_MODE = 1'b1;
`else
  localparam logic TOGGLE_MODE = 1'b0;
`endif

  always_comb begin
    j_next = '0;
    k_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_next[i], k_next[i]} = jk_bit(TOGGLE_MODE, q[i], t[i]);
    end
  end

endmodule

// File: rtl/jk_target_driver.sv
// Drives J/K of an external JK bank until it reaches an accepted target, then
// pulses done, or pulses err after MAX_TRIES drive attempts without a match.
// Ports: clk, clear_n (async active-low), bus (jk_target_driver_if.slave):
//   tgt_valid/tgt_ready/tgt_data handshake, q_fb feedback, registered j/k,
//   busy (state != IDLE), done/err one-cycle registered pulses.
// Timing: accept at E0 -> j/k valid E0..E1 -> CHECK compares q_fb at E2 -> done in E2..E3.
// Optional macro JK_TOGGLE_EN (handled in jk_excite) selects toggle excitation.
module jk_target_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 3
) (
  input logic              clk,
  input logic              clear_n,
  jk_target_driver_if.slave bus
);

  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     tgt_q, tgt_d;
  logic [WIDTH-1:0]     j_q, j_d, k_q, k_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 done_q, done_d, err_q, err_d;

  logic                 accept;
  logic                 match;
  logic                 retry;
  logic [WIDTH-1:0]     ex_t, ex_j, ex_k;

  assign accept = bus.tgt_valid && (state_q == IDLE);
  assign match  = (bus.q_fb == tgt_q);
  assign retry  = (state_q == CHECK) && !match && (tries_q < MAX_T);

  // One excitation instance serves both acceptance (fresh tgt_data) and
  // retries (latched target); q_fb is only consumed in those two cases.
  assign ex_t = (state_q == IDLE) ? bus.tgt_data : tgt_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q      (bus.q_fb),
    .t      (ex_t),
    .j_next (ex_j),
    .k_next (ex_k)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      tries_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tries_q <= tries_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = retry ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    tgt_d   = tgt_q;
    tries_d = tries_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = bus.tgt_data;
          tries_d = TRIES_W'(1);
          j_d     = ex_j;
          k_d     = ex_k;
        end
      end
      CHECK: begin
        if (match) begin
          done_d = 1'b1;
        end else if (retry) begin
          tries_d = tries_q + TRIES_W'(1);
          j_d     = ex_j;
          k_d     = ex_k;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
